// File: rtl/nbit_stream_accumulator.sv
// ============================================================================
// Module   : nbit_stream_accumulator (with nbit_carrylookahead)
// Brief    : Saturating signed packet accumulator on valid/ready streams.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nbit_carrylookahead #(
  parameter int WIDTH = 11
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Each carry is the flat sum-of-products of all lower generates and the carry-in.
  always_comb begin : p_carry
    logic w_pp;
    logic w_ci;
    w_c    = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < WIDTH; i++) begin
      w_pp = 1'b1;
      w_ci = 1'b0;
      for (int j = i; j >= 0; j--) begin
        w_ci = w_ci | (w_pp & w_g[j]);
        w_pp = w_pp & w_p[j];
      end
      w_c[i+1] = w_ci | (w_pp & i_cin);
    end
  end

  assign o_sum  = w_p ^ w_c[WIDTH-1:0];
  assign o_cout = w_c[WIDTH];
endmodule

module nbit_stream_accumulator #(
  parameter int WIDTH   = 11,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sat,
  output logic [COUNT_W-1:0] out_count
);
  localparam logic [1:0]         c_IDLE      = 2'd0;
  localparam logic [1:0]         c_ACCUM     = 2'd1;
  localparam logic [1:0]         c_HOLD      = 2'd2;
  localparam logic [COUNT_W-1:0] c_COUNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] c_COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   c_POS_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   c_NEG_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [WIDTH-1:0]   r_acc;
  logic               r_sat;
  logic [COUNT_W-1:0] r_count;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout_unused;
  logic               w_ovf;
  logic               w_first;
  logic               w_accept;
  logic [WIDTH-1:0]   w_acc_next;

  assign w_first  = (r_state == c_IDLE);
  assign w_accept = in_valid & in_ready;
  assign w_a      = w_first ? '0 : r_acc;

  nbit_carrylookahead #(
    .WIDTH (WIDTH)
  ) u_cla (
    .i_a    (w_a),
    .i_b    (in_data),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout_unused)
  );

  // Signed overflow: operands agree in sign but the sum does not.
  assign w_ovf      = (w_a[WIDTH-1] == in_data[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
  assign w_acc_next = w_ovf ? (w_a[WIDTH-1] ? c_NEG_MIN : c_POS_MAX) : w_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_next_state = in_last ? c_HOLD : c_ACCUM;
      c_ACCUM: if (w_accept && in_last) w_next_state = c_HOLD;
      c_HOLD:  if (out_ready) w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state != c_HOLD);
    out_valid = (r_state == c_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_sat   <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_acc <= w_acc_next;
      r_sat <= w_first ? w_ovf : (r_sat | w_ovf);
      if (w_first) begin
        r_count <= c_COUNT_ONE;
      end else if (r_count != c_COUNT_MAX) begin
        r_count <= r_count + c_COUNT_ONE;
      end
    end
  end

  assign out_data  = r_acc;
  assign out_sat   = r_sat;
  assign out_count = r_count;
endmodule

`default_nettype wire

// File: tb/tb_nbit_stream_accumulator.sv
// ============================================================================
// Module   : tb_nbit_stream_accumulator
// Brief    : Scoreboard bench for nbit_stream_accumulator against a clamp model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nbit_stream_accumulator;
  localparam int WIDTH   = 11;
  localparam int COUNT_W = 4;
  localparam int MAXV    = (1 << (WIDTH - 1)) - 1;
  localparam int MINV    = -(1 << (WIDTH - 1));
  localparam int CMAX    = (1 << COUNT_W) - 1;

  logic               clk       = 1'b0;
  logic               rst_n     = 1'b0;
  logic               in_valid  = 1'b0;
  logic               in_last   = 1'b0;
  logic               out_ready = 1'b1;
  logic [WIDTH-1:0]   in_data   = '0;
  logic               in_ready;
  logic               out_valid;
  logic               out_sat;
  logic [WIDTH-1:0]   out_data;
  logic [COUNT_W-1:0] out_count;

  typedef struct {
    int data;
    int sat;
    int count;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec      = 0;
  int   n_err      = 0;
  int   ready_mode = 0;
  int   gap_max    = 0;

  nbit_stream_accumulator #(
    .WIDTH   (WIDTH),
    .COUNT_W (COUNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Reference: packet sum clamped to the signed range after every term.
  task automatic push_model(input int t[$]);
    exp_t e;
    int   acc;
    acc   = 0;
    e.sat = 0;
    foreach (t[i]) begin
      acc += t[i];
      if (acc > MAXV) begin
        acc   = MAXV;
        e.sat = 1;
      end else if (acc < MINV) begin
        acc   = MINV;
        e.sat = 1;
      end
    end
    e.data  = acc;
    e.count = (t.size() > CMAX) ? CMAX : t.size();
    exp_q.push_back(e);
  endtask

  // Monitor: compare every presented result against the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got out_data=%0d, expected no result", $signed(out_data));
      end else begin
        check("out_data", int'($signed(out_data)), exp_q[0].data);
        check("out_sat", int'(out_sat), exp_q[0].sat);
        check("out_count", int'(out_count), exp_q[0].count);
        check("in_ready_in_hold", int'(in_ready), 0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send_beat(input int d, input bit last, output bit ok);
    int g;
    g  = $urandom_range(0, gap_max);
    ok = 1'b0;
    if (g > 0) begin
      repeat (g) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d[WIDTH-1:0];
    in_last  = last;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL beat_accept_timeout: got no accept in 200 cycles, expected accept of %0d", d);
    end
  endtask

  task automatic run_packet(input int t[$]);
    bit ok;
    bit all_ok;
    all_ok = 1'b1;
    foreach (t[i]) begin
      send_beat(t[i], (i == t.size() - 1), ok);
      all_ok = all_ok & ok;
    end
    if (all_ok) begin
      push_model(t);
      @(negedge clk);
      check("latency_out_valid", int'(out_valid), 1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 500; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    check("drain_queue_empty", exp_q.size(), 0);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t[$];
    bit ok;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_sat", int'(out_sat), 0);
    check("reset_out_count", int'(out_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_in_ready", int'(in_ready), 1);

    t = {100, 200, -50};
    run_packet(t);
    check("after_hs_out_valid", int'(out_valid), 0);
    check("after_hs_in_ready", int'(in_ready), 1);

    t = {1000, 30};
    run_packet(t);
    t = {5};
    run_packet(t);
    t = {-1000, -100, 50};
    run_packet(t);
    wait_drain();

    // Result held off for several cycles while the next term is already waiting.
    ready_mode = 2;
    out_ready  = 1'b0;
    t = {7, 8};
    run_packet(t);
    fork
      begin
        repeat (5) @(posedge clk);
        #1;
        ready_mode = 0;
        out_ready  = 1'b1;
      end
    join_none
    t = {3};
    run_packet(t);
    wait_drain();

    send_beat(300, 1'b0, ok);
    send_beat(400, 1'b0, ok);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_data", int'(out_data), 0);
    check("async_rst_out_count", int'(out_count), 0);
    check("async_rst_out_sat", int'(out_sat), 0);
    check("async_rst_out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    t = {9};
    run_packet(t);

    t = {};
    for (int i = 0; i < 20; i++) t.push_back(1);
    run_packet(t);
    wait_drain();

    ready_mode = 1;
    gap_max    = 2;
    for (int p = 0; p < 40; p++) begin
      int n;
      bit wide;
      n    = $urandom_range(1, 20);
      wide = ($urandom_range(0, 2) != 0);
      t    = {};
      for (int i = 0; i < n; i++) begin
        if (wide) t.push_back(int'($urandom_range(0, 2047)) - 1024);
        else      t.push_back(int'($urandom_range(0, 60)) - 30);
      end
      run_packet(t);
    end
    ready_mode = 0;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
